// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit with bus handshake FSM, lane alignment, split beats and timeout
//
// Purpose: replaces the combinational MEM stage. Memory ops are run on the data
// bus through a request/acknowledge FSM (IDLE, REQ0, REQ1, DONE); non-memory ops
// pass straight through to MEM/WB.
// Optional feature macro: MISALIGN_SPLIT_EN (defined: misaligned accesses are
// split into two word beats; undefined: they are flagged and not issued).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   waddr_i, we_i, wdata_i      writeback request from EX
//   mem_addr_i, mem_aluop_i     byte address and operation
//   rt_data_i                   store data
//   waddr_o, we_o, wdata_o      writeback to MEM/WB
//   mem_stallreq                pipeline hold while an access is in flight
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata           registered bus request
//   bus_ack, bus_rdata          one-cycle completion and read word
//   misalign_o                  one-cycle pulse, misaligned access (unsplit build)
//   bus_err_o                   one-cycle pulse, ack timeout abort
module mem_lsu #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [XLEN-1:0]       mem_addr_i,
    input  logic [ALUOP_W-1:0]    mem_aluop_i,
    input  logic [XLEN-1:0]       rt_data_i,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  mem_stallreq,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [XLEN-1:0]       bus_addr,
    output logic [XLEN/8-1:0]     bus_be,
    output logic [XLEN-1:0]       bus_wdata,
    input  logic                  bus_ack,
    input  logic [XLEN-1:0]       bus_rdata,
    output logic                  misalign_o,
    output logic                  bus_err_o
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = ALUOP_W'(8'b1110_0000);
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = ALUOP_W'(8'b1110_0001);
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = ALUOP_W'(8'b1110_0011);
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = ALUOP_W'(8'b1110_0100);
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = ALUOP_W'(8'b1110_0101);
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = ALUOP_W'(8'b1110_1000);
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = ALUOP_W'(8'b1110_1001);
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = ALUOP_W'(8'b1110_1011);

    typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic [2*XLEN-1:0]   rbuf_q, rbuf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                misalign_q, misalign_d;
    logic                bus_err_q, bus_err_d;
    logic                abort_q, abort_d;

    logic                is_load, is_store, is_mem, sz_b, sz_h, sz_w, sign_ext;
    logic [OFF_W-1:0]    off;
    logic                misaligned, crosses, timed_out;
    logic [2*NB-1:0]     mask, be_win;
    logic [2*XLEN-1:0]   wdata_win;
    logic [XLEN-1:0]     word_addr, load_shift, load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        sz_w     = 1'b0;
        sign_ext = 1'b0;
        case (mem_aluop_i)
            EXE_LB_OP:  begin is_load  = 1'b1; sz_b = 1'b1; sign_ext = 1'b1; end
            EXE_LH_OP:  begin is_load  = 1'b1; sz_h = 1'b1; sign_ext = 1'b1; end
            EXE_LW_OP:  begin is_load  = 1'b1; sz_w = 1'b1; end
            EXE_LBU_OP: begin is_load  = 1'b1; sz_b = 1'b1; end
            EXE_LHU_OP: begin is_load  = 1'b1; sz_h = 1'b1; end
            EXE_SB_OP:  begin is_store = 1'b1; sz_b = 1'b1; end
            EXE_SH_OP:  begin is_store = 1'b1; sz_h = 1'b1; end
            EXE_SW_OP:  begin is_store = 1'b1; sz_w = 1'b1; end
            default: ;
        endcase
    end

    // Byte lanes and store data live in a two-word window: the low word is
    // beat 0, the high word is beat 1 when the access crosses a word boundary.
    always_comb begin
        is_mem     = is_load | is_store;
        off        = mem_addr_i[OFF_W-1:0];
        misaligned = (sz_h && off[0]) || (sz_w && (off != '0));
        mask       = sz_b ? (2*NB)'(1) : sz_h ? (2*NB)'(3) : sz_w ? (2*NB)'(4'hF) : '0;
        be_win     = mask << off;
        wdata_win  = {{XLEN{1'b0}}, rt_data_i} << {off, 3'b000};
        crosses    = |be_win[2*NB-1:NB];
        word_addr  = {mem_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        load_shift = XLEN'(rbuf_q >> {off, 3'b000});
        if (sz_b) begin
            load_val = {{(XLEN-8){sign_ext & load_shift[7]}}, load_shift[7:0]};
        end else if (sz_h) begin
            load_val = {{(XLEN-16){sign_ext & load_shift[15]}}, load_shift[15:0]};
        end else begin
            load_val = load_shift;
        end
        timed_out  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rbuf_d      = rbuf_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    if (misaligned && !SPLIT) begin
                        // Unsplit build: flag it and finish without touching the bus.
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        abort_d    = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = word_addr;
                        bus_be_d    = be_win[NB-1:0];
                        bus_wdata_d = wdata_win[XLEN-1:0];
                    end
                end
            end
            REQ0: begin
                if (bus_ack) begin
                    rbuf_d[XLEN-1:0] = bus_rdata;
                    cnt_d            = '0;
                    if (SPLIT && crosses) begin
                        state_d     = REQ1;
                        bus_addr_d  = word_addr + XLEN'(NB);
                        bus_be_d    = be_win[2*NB-1:NB];
                        bus_wdata_d = wdata_win[2*XLEN-1:XLEN];
                    end else begin
                        state_d   = DONE;
                        bus_req_d = 1'b0;
                    end
                end else if (timed_out) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    abort_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1: begin
                if (bus_ack) begin
                    rbuf_d[2*XLEN-1:XLEN] = bus_rdata;
                    state_d               = DONE;
                    bus_req_d             = 1'b0;
                end else if (timed_out) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    abort_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rbuf_q      <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rbuf_q      <= rbuf_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Writeback: zero while stalled so nothing partial is forwarded; in DONE a
    // load returns the extracted value unless it was aborted.
    always_comb begin
        mem_stallreq = !rst && is_mem && (state_q != DONE);
        waddr_o      = waddr_i;
        we_o         = we_i;
        wdata_o      = wdata_i;
        if (rst) begin
            waddr_o = '0;
            we_o    = 1'b0;
            wdata_o = '0;
        end else if (mem_stallreq) begin
            we_o    = 1'b0;
            wdata_o = '0;
        end else if (state_q == DONE) begin
            if (abort_q) begin
                we_o = 1'b0;
            end
            if (is_load) begin
                wdata_o = abort_q ? '0 : load_val;
            end
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign misalign_o = SPLIT ? 1'b0 : misalign_q;
    assign bus_err_o  = bus_err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu: vector table, bus responder, scoreboard
module tb_mem_lsu;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  waddr_i, waddr_o;
    logic        we_i, we_o;
    logic [31:0] wdata_i, wdata_o, mem_addr_i, rt_data_i;
    logic [7:0]  mem_aluop_i;
    logic        mem_stallreq, bus_req, bus_we, bus_ack, misalign_o, bus_err_o;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    mem_lsu #(.XLEN(32), .REG_ADDR_W(5), .ALUOP_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
        .mem_addr_i(mem_addr_i), .mem_aluop_i(mem_aluop_i), .rt_data_i(rt_data_i),
        .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
        .mem_stallreq(mem_stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic        we;
        logic [31:0] wd_in;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          ack_wait;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] bw0;
        logic [31:0] bw1;
        int          req_cyc;
        int          stall_cyc;
        logic        we_x;
        logic        chk_wd;
        logic [31:0] wd_x;
        logic        mis_x;
        logic        err_x;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic set_nop();
        mem_aluop_i = OP_NOP;
        mem_addr_i  = '0;
        rt_data_i   = '0;
        we_i        = 1'b0;
        wdata_i     = '0;
        waddr_i     = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
    endtask

    // Called at a falling edge; drives one op, answers bus requests, and
    // scores the writeback when the stall drops.
    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        int   cyc, acks, wcnt, reqc, stallc;
        bit   done, is_st;
        is_st       = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
        mem_aluop_i = v.op;
        mem_addr_i  = v.addr;
        rt_data_i   = v.rt;
        we_i        = v.we;
        wdata_i     = v.wd_in;
        waddr_i     = 5'd9;
        exp_q.push_back(v);
        #1;
        chk($sformatf("v%0d_req_idle", idx), {31'b0, bus_req}, 32'd0);
        cyc = 0; acks = 0; wcnt = 0; reqc = 0; stallc = 0; done = 0;
        while (!done && cyc < 40) begin
            if (bus_req) begin
                reqc++;
                chk($sformatf("v%0d_addr", idx), bus_addr, v.a0 + ((acks != 0) ? 32'd4 : 32'd0));
                chk($sformatf("v%0d_be", idx), {28'b0, bus_be}, {28'b0, (acks != 0) ? v.be1 : v.be0});
                chk($sformatf("v%0d_we", idx), {31'b0, bus_we}, {31'b0, is_st});
                if (is_st)
                    chk($sformatf("v%0d_bwdata", idx), bus_wdata, (acks != 0) ? v.bw1 : v.bw0);
                if (wcnt == v.ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = (acks != 0) ? v.rd1 : v.rd0;
                    acks++;
                    wcnt = 0;
                end else begin
                    bus_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus_ack = 1'b0;
            end
            if (!mem_stallreq) begin
                done = 1;
                e = exp_q.pop_front();
                chk($sformatf("v%0d_stall_cyc", idx), stallc, e.stall_cyc);
                chk($sformatf("v%0d_req_cyc", idx), reqc, e.req_cyc);
                chk($sformatf("v%0d_we_o", idx), {31'b0, we_o}, {31'b0, e.we_x});
                if (e.chk_wd)
                    chk($sformatf("v%0d_wdata_o", idx), wdata_o, e.wd_x);
                chk($sformatf("v%0d_waddr_o", idx), {27'b0, waddr_o}, 32'd9);
                chk($sformatf("v%0d_misalign", idx), {31'b0, misalign_o}, {31'b0, e.mis_x});
                chk($sformatf("v%0d_bus_err", idx), {31'b0, bus_err_o}, {31'b0, e.err_x});
            end else begin
                stallc++;
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL v%0d_budget: stall still %0b after %0d cycles, want release", idx, mem_stallreq, cyc);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        set_nop();
    endtask

    initial begin
        // op addr rt we wd_in rd0 rd1 wait | a0 be0 be1 bw0 bw1 req stall we_x chk wd_x mis err
        vecs.push_back('{OP_LW,  32'h100, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 0,
                         32'h100, 4'hF, 4'h0, 32'h0, 32'h0, 1, 2, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
        vecs.push_back('{OP_LB,  32'h103, 32'h0, 1'b1, 32'h0, 32'h80FF1122, 32'h0, 0,
                         32'h100, 4'h8, 4'h0, 32'h0, 32'h0, 1, 2, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0});
        vecs.push_back('{OP_LBU, 32'h103, 32'h0, 1'b1, 32'h0, 32'h80FF1122, 32'h0, 1,
                         32'h100, 4'h8, 4'h0, 32'h0, 32'h0, 2, 3, 1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0});
        vecs.push_back('{OP_SH,  32'h102, 32'h0000ABCD, 1'b0, 32'h0BADF00D, 32'h0, 32'h0, 0,
                         32'h100, 4'hC, 4'h0, 32'hABCD0000, 32'h0, 1, 2, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0});
        vecs.push_back('{OP_LH,  32'h102, 32'h0, 1'b1, 32'h0, 32'h80010000, 32'h0, 2,
                         32'h100, 4'hC, 4'h0, 32'h0, 32'h0, 3, 4, 1'b1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0});
        vecs.push_back('{OP_LHU, 32'h106, 32'h0, 1'b1, 32'h0, 32'h80017777, 32'h0, 0,
                         32'h104, 4'hC, 4'h0, 32'h0, 32'h0, 1, 2, 1'b1, 1'b1, 32'h00008001, 1'b0, 1'b0});
        vecs.push_back('{OP_SB,  32'h101, 32'h000000A5, 1'b0, 32'h0, 32'h0, 32'h0, 0,
                         32'h100, 4'h2, 4'h0, 32'h0000A500, 32'h0, 1, 2, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{OP_SW,  32'h200, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 32'h0, 1,
                         32'h200, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 2, 3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{8'h21,  32'h104, 32'h0, 1'b1, 32'h000055AA, 32'h0, 32'h0, 0,
                         32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b1, 32'h000055AA, 1'b0, 1'b0});
        vecs.push_back('{OP_LW,  32'h300, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 99,
                         32'h300, 4'hF, 4'h0, 32'h0, 32'h0, 4, 5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back('{OP_LW,  32'h101, 32'h0, 1'b1, 32'h0, 32'h44332211, 32'h88776655, 0,
                         32'h100, 4'hE, 4'h1, 32'h0, 32'h0, 2, 3, 1'b1, 1'b1, 32'h55443322, 1'b0, 1'b0});
        vecs.push_back('{OP_LH,  32'h103, 32'h0, 1'b1, 32'h0, 32'hAB000000, 32'h000000CD, 0,
                         32'h100, 4'h8, 4'h1, 32'h0, 32'h0, 2, 3, 1'b1, 1'b1, 32'hFFFFCDAB, 1'b0, 1'b0});
        vecs.push_back('{OP_SW,  32'h102, 32'h11223344, 1'b0, 32'h0, 32'h0, 32'h0, 0,
                         32'h100, 4'hC, 4'h3, 32'h33440000, 32'h00001122, 2, 3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{OP_LH,  32'h101, 32'h0, 1'b1, 32'h0, 32'h00BEEF00, 32'h0, 0,
                         32'h100, 4'h6, 4'h0, 32'h0, 32'h0, 1, 2, 1'b1, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0});
`else
        vecs.push_back('{OP_LW,  32'h101, 32'h0, 1'b1, 32'h0, 32'h44332211, 32'h88776655, 0,
                         32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{OP_LH,  32'h103, 32'h0, 1'b1, 32'h0, 32'hAB000000, 32'h000000CD, 0,
                         32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{OP_SW,  32'h102, 32'h11223344, 1'b0, 32'h0, 32'h0, 32'h0, 0,
                         32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{OP_LH,  32'h101, 32'h0, 1'b1, 32'h0, 32'h00BEEF00, 32'h0, 0,
                         32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
`endif

        // Reset with a memory op already presented: outputs forced to zero.
        set_nop();
        mem_aluop_i = OP_LW;
        mem_addr_i  = 32'h100;
        we_i        = 1'b1;
        wdata_i     = 32'hFFFFFFFF;
        waddr_i     = 5'd3;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_stall", {31'b0, mem_stallreq}, 32'd0);
        chk("rst_we_o", {31'b0, we_o}, 32'd0);
        chk("rst_wdata_o", wdata_o, 32'd0);
        chk("rst_waddr_o", {27'b0, waddr_o}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        set_nop();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of REQ0, then a late ack that must be ignored.
        mem_aluop_i = OP_LW;
        mem_addr_i  = 32'h400;
        we_i        = 1'b1;
        waddr_i     = 5'd4;
        @(negedge clk);
        #1;
        chk("mid_req_before_rst", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, mem_stallreq}, 32'd0);
        chk("mid_rst_we_o", {31'b0, we_o}, 32'd0);
        @(negedge clk);
        set_nop();
        rst = 1'b0;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("late_ack_req_%0d", k), {31'b0, bus_req}, 32'd0);
            chk($sformatf("late_ack_stall_%0d", k), {31'b0, mem_stallreq}, 32'd0);
            chk($sformatf("late_ack_we_%0d", k), {31'b0, we_o}, 32'd0);
            chk($sformatf("late_ack_wdata_%0d", k), wdata_o, 32'd0);
            chk($sformatf("late_ack_err_%0d", k), {31'b0, bus_err_o}, 32'd0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        run_vec(100, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
